bootrom_arbiter: RTL and testbench



---
 rtl/bootrom_arbiter.sv | 118 +++++++++++
 tb/tb_bootrom_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bootrom_arbiter.sv
// bootrom_arbiter: shares one single-ported boot ROM between iport and dport.
// Define BOOTROM_ARB_RR_EN for round-robin; default is fixed iport priority.
module bootrom_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iport_address,
  input  logic        iport_valid,
  output logic [31:0] iport_rdata,
  output logic        iport_ready,
  output logic        iport_error,
  input  logic [31:0] dport_address,
  input  logic        dport_valid,
  output logic [31:0] dport_rdata,
  output logic        dport_ready,
  output logic        dport_error,
  output logic [31:0] rom_address,
  output logic        rom_valid,
  input  logic [31:0] rom_rdata,
  input  logic        rom_ready,
  input  logic        rom_error
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ERR
  } state_t;

  state_t        state, state_n;
  logic          grant, grant_n;
  logic          last, last_n;
  logic [31:0]   addr_q, addr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          winner;
  logic          busy;
  logic          done;
  logic          fail;

`ifdef BOOTROM_ARB_RR_EN
  // Contended requests go to the port that was not served last.
  assign winner = (iport_valid && dport_valid) ? ~last : dport_valid;
`else
  // iport wins any contention; dport wins only when alone.
  assign winner = ~iport_valid;
`endif

  // State and access registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= 1'b0;
      last   <= 1'b1;
      addr_q <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      grant  <= grant_n;
      last   <= last_n;
      addr_q <= addr_n;
      cnt    <= cnt_n;
    end
  end

  // Next-state: grant in IDLE, exit BUSY on response or timeout.
  always_comb begin
    state_n = state;
    grant_n = grant;
    last_n  = last;
    addr_n  = addr_q;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (iport_valid || dport_valid) begin
          grant_n = winner;
          last_n  = winner;
          addr_n  = winner ? dport_address : iport_address;
          cnt_n   = '0;
          state_n = (addr_n[1:0] != 2'b00) ? ERR : BUSY;
        end
      end
      BUSY: begin
        if (rom_ready || rom_error || cnt == CNT_MAX) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ERR: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Outputs decode registered state plus the ROM response only.
  always_comb begin
    busy        = (state == BUSY);
    done        = busy & rom_ready;
    fail        = (state == ERR)
                | (busy & ~rom_ready & (rom_error | (cnt == CNT_MAX)));
    rom_valid   = busy;
    rom_address = addr_q;
    iport_ready = done & ~grant;
    dport_ready = done & grant;
    iport_error = fail & ~grant;
    dport_error = fail & grant;
    iport_rdata = rom_rdata;
    dport_rdata = rom_rdata;
  end

endmodule

// File: tb/tb_bootrom_arbiter.sv
// tb_bootrom_arbiter: directed and random checks of bootrom_arbiter
// against a transaction-level reference model (TIMEOUT=4).
module tb_bootrom_arbiter;

  localparam int TO = 4;
  localparam logic [31:0] MEM1 = 32'hCAFE_0001;

`ifdef BOOTROM_ARB_RR_EN
  localparam int EXP_I = 2;
  localparam int EXP_D = 2;
`else
  localparam int EXP_I = 4;
  localparam int EXP_D = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] iport_address = '0;
  logic        iport_valid = 1'b0;
  logic [31:0] iport_rdata;
  logic        iport_ready;
  logic        iport_error;
  logic [31:0] dport_address = '0;
  logic        dport_valid = 1'b0;
  logic [31:0] dport_rdata;
  logic        dport_ready;
  logic        dport_error;
  logic [31:0] rom_address;
  logic        rom_valid;
  logic [31:0] rom_rdata = '0;
  logic        rom_ready = 1'b0;
  logic        rom_error = 1'b0;

  logic [4:0]  obs;
  assign obs = {rom_valid, iport_ready, iport_error,
                dport_ready, dport_error};

  int checks = 0;
  int errors = 0;

  // reference model: who owns the ROM and for how long
  int          m_own = -1;
  bit          m_bad = 1'b0;
  int          m_age = 0;
  int          m_last = 1;
  logic [31:0] m_addr = '0;

  bit          e_rv, e_ir, e_ie, e_dr, e_de;
  logic [4:0]  e_ctl;
  logic [31:0] e_addr, e_rdata;

  bootrom_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .iport_address(iport_address),
    .iport_valid(iport_valid),
    .iport_rdata(iport_rdata),
    .iport_ready(iport_ready),
    .iport_error(iport_error),
    .dport_address(dport_address),
    .dport_valid(dport_valid),
    .dport_rdata(dport_rdata),
    .dport_ready(dport_ready),
    .dport_error(dport_error),
    .rom_address(rom_address),
    .rom_valid(rom_valid),
    .rom_rdata(rom_rdata),
    .rom_ready(rom_ready),
    .rom_error(rom_error)
  );

  always #5 clk = ~clk;

  // drive one cycle of inputs, predict outputs, wait to mid-cycle
  task automatic step(input bit r, input bit iv, input logic [31:0] ia,
                      input bit dv, input logic [31:0] da,
                      input bit rr, input bit re, input logic [31:0] rd);
    int w;
    @(posedge clk);
    #1;
    rst = r;
    iport_valid = iv;
    iport_address = ia;
    dport_valid = dv;
    dport_address = da;
    rom_ready = rr;
    rom_error = re;
    rom_rdata = rd;
    e_rv = 0; e_ir = 0; e_ie = 0; e_dr = 0; e_de = 0;
    e_addr = m_addr;
    e_rdata = rd;
    if (m_own >= 0) begin
      if (m_bad) begin
        if (m_own == 0) e_ie = 1; else e_de = 1;
        m_own = -1;
      end else begin
        e_rv = 1;
        m_age++;
        if (rr) begin
          if (m_own == 0) e_ir = 1; else e_dr = 1;
          m_own = -1;
        end else if (re || m_age == TO) begin
          if (m_own == 0) e_ie = 1; else e_de = 1;
          m_own = -1;
        end
      end
    end else if (iv || dv) begin
`ifdef BOOTROM_ARB_RR_EN
      if (iv && dv) w = (m_last == 0) ? 1 : 0;
      else w = dv ? 1 : 0;
`else
      w = iv ? 0 : 1;
`endif
      m_own = w;
      m_last = w;
      m_addr = (w == 1) ? da : ia;
      m_bad = (m_addr[1:0] != 2'b00);
      m_age = 0;
    end
    if (r) begin
      m_own = -1;
      m_last = 1;
      m_addr = '0;
      m_age = 0;
    end
    e_ctl = {e_rv, e_ir, e_ie, e_dr, e_de};
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      step(1, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs !== 5'b0) begin
        errors++;
        $display("FAIL reset_ctl cyc=%0d got=%b exp=00000", k, obs);
      end
      checks++;
      if (rom_address !== 32'h0) begin
        errors++;
        $display("FAIL reset_addr got=%h exp=0", rom_address);
      end
    end
  endtask

  task automatic test_aligned_read();
    bit          v[4]  = '{1, 1, 1, 0};
    bit          rr[4] = '{0, 0, 1, 0};
    for (int k = 0; k < 4; k++) begin
      step(0, v[k], 32'h4, 0, 32'h8, rr[k], 0, MEM1);
      checks++;
      if (obs !== e_ctl) begin
        errors++;
        $display("FAIL aligned_ctl cyc=%0d got=%b exp=%b", k, obs, e_ctl);
      end
      if (k == 1) begin
        checks++;
        if (rom_valid !== 1'b1 || rom_address !== 32'h4) begin
          errors++;
          $display("FAIL aligned_req got v=%b a=%h exp v=1 a=4",
                   rom_valid, rom_address);
        end
      end
      if (k == 2) begin
        checks++;
        if (iport_ready !== 1'b1 || iport_rdata !== MEM1
            || dport_ready !== 1'b0) begin
          errors++;
          $display("FAIL aligned_rsp got r=%b d=%h dr=%b exp r=1 d=%h dr=0",
                   iport_ready, iport_rdata, dport_ready, MEM1);
        end
      end
    end
  endtask

  task automatic test_contention();
    int  ic = 0;
    int  dc = 0;
    bit  rr;
    for (int k = 0; k < 18; k++) begin
      rr = (m_own >= 0 && !m_bad && m_age == 1);
      step(0, k < 12, 32'h0, 1, 32'h8, rr, 0, 32'(k));
      checks++;
      if (obs !== e_ctl) begin
        errors++;
        $display("FAIL contend_ctl cyc=%0d got=%b exp=%b", k, obs, e_ctl);
      end
      if (e_rv) begin
        checks++;
        if (rom_address !== e_addr) begin
          errors++;
          $display("FAIL contend_addr cyc=%0d got=%h exp=%h",
                   k, rom_address, e_addr);
        end
      end
      if (k < 12) begin
        ic += int'(iport_ready);
        dc += int'(dport_ready);
      end else if (k == 12) begin
        checks++;
        if (ic !== EXP_I || dc !== EXP_D) begin
          errors++;
          $display("FAIL contend_share got i=%0d d=%0d exp i=%0d d=%0d",
                   ic, dc, EXP_I, EXP_D);
        end
        dc = 0;
      end else begin
        dc += int'(dport_ready);
      end
    end
    checks++;
    if (dc !== 2) begin
      errors++;
      $display("FAIL contend_dalone got=%0d exp=2", dc);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_misaligned();
    int rv = 0;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, k < 2, 32'h2, 1, 1, 32'hDEAD);
      checks++;
      if (obs !== e_ctl) begin
        errors++;
        $display("FAIL misalign_ctl cyc=%0d got=%b exp=%b", k, obs, e_ctl);
      end
      rv += int'(rom_valid);
      if (k == 1) begin
        checks++;
        if (dport_error !== 1'b1 || dport_ready !== 1'b0) begin
          errors++;
          $display("FAIL misalign_err got e=%b r=%b exp e=1 r=0",
                   dport_error, dport_ready);
        end
      end
    end
    checks++;
    if (rv !== 0) begin
      errors++;
      $display("FAIL misalign_romvalid got=%0d exp=0", rv);
    end
  endtask

  task automatic test_timeout(input bit late_ready);
    int rv = 0;
    for (int k = 0; k < 6; k++) begin
      step(0, k < 5, 32'h40, 0, 0, late_ready && k == 4, 0, 32'h1234);
      checks++;
      if (obs !== e_ctl) begin
        errors++;
        $display("FAIL timeout_ctl lr=%0d cyc=%0d got=%b exp=%b",
                 late_ready, k, obs, e_ctl);
      end
      rv += int'(rom_valid);
      if (k == 4) begin
        checks++;
        if (iport_ready !== late_ready || iport_error !== !late_ready) begin
          errors++;
          $display("FAIL timeout_end lr=%0d got r=%b e=%b exp r=%0d e=%0d",
                   late_ready, iport_ready, iport_error,
                   late_ready, !late_ready);
        end
      end
    end
    checks++;
    if (rv !== TO) begin
      errors++;
      $display("FAIL timeout_busy got=%0d exp=%0d", rv, TO);
    end
  endtask

  task automatic test_reset_mid_access();
    bit v[7]  = '{1, 1, 1, 1, 1, 0, 0};
    bit dv[7] = '{0, 1, 1, 1, 1, 0, 0};
    bit r[7]  = '{0, 1, 0, 0, 0, 0, 0};
    bit rr[7] = '{0, 0, 1, 0, 1, 0, 0};
    for (int k = 0; k < 7; k++) begin
      step(r[k], v[k], 32'h10, dv[k], 32'h20, rr[k], 0, 32'h55);
      checks++;
      if (obs !== e_ctl) begin
        errors++;
        $display("FAIL rstmid_ctl cyc=%0d got=%b exp=%b", k, obs, e_ctl);
      end
      if (k == 2) begin
        checks++;
        if (obs !== 5'b0) begin
          errors++;
          $display("FAIL rstmid_quiet got=%b exp=00000", obs);
        end
      end
      if (k == 3) begin
        checks++;
        if (rom_valid !== 1'b1 || rom_address !== 32'h10) begin
          errors++;
          $display("FAIL rstmid_regrant got v=%b a=%h exp v=1 a=10",
                   rom_valid, rom_address);
        end
      end
    end
  endtask

  task automatic test_random();
    bit          iv = 0;
    bit          dv = 0;
    logic [31:0] ia = '0;
    logic [31:0] da = '0;
    for (int k = 0; k < 600; k++) begin
      if (!iv && $urandom_range(0, 2) == 0) begin
        iv = 1;
        ia = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 3) == 0) ia[1:0] = 2'($urandom_range(1, 3));
      end
      if (!dv && $urandom_range(0, 2) == 0) begin
        dv = 1;
        da = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 3) == 0) da[1:0] = 2'($urandom_range(1, 3));
      end
      step($urandom_range(0, 63) == 0, iv, ia, dv, da,
           $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
           $urandom);
      checks++;
      if (obs !== e_ctl) begin
        errors++;
        $display("FAIL random_ctl cyc=%0d got=%b exp=%b", k, obs, e_ctl);
      end
      if (e_rv) begin
        checks++;
        if (rom_address !== e_addr) begin
          errors++;
          $display("FAIL random_addr cyc=%0d got=%h exp=%h",
                   k, rom_address, e_addr);
        end
      end
      if (e_ir || e_dr) begin
        checks++;
        if ((e_ir ? iport_rdata : dport_rdata) !== e_rdata) begin
          errors++;
          $display("FAIL random_rdata cyc=%0d got=%h/%h exp=%h",
                   k, iport_rdata, dport_rdata, e_rdata);
        end
      end
      if (e_ir || e_ie || $urandom_range(0, 15) == 0) iv = 0;
      if (e_dr || e_de || $urandom_range(0, 15) == 0) dv = 0;
    end
  endtask

  initial begin
    test_reset();
    test_aligned_read();
    test_contention();
    test_misaligned();
    test_timeout(0);
    test_timeout(1);
    test_reset_mid_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
